// File: rtl/bcd_conv_scheduler_if.sv
// Bundle between value sources and the shared binary-to-BCD scheduler.
// Handshake: a requester holds req[i] and its bin_in slice stable until it sees grant[i].
// grant[i] is a 1-cycle pulse that marks the capture of that operand.
// done is a 1-cycle pulse, and the digits plus done_id stay valid until the next done.
interface bcd_conv_scheduler_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] bin_in;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     done;
  logic [1:0]               done_id;
  logic [3:0]               hundreds;
  logic [3:0]               tens;
  logic [3:0]               ones;

  modport master (
    output req, bin_in,
    input  grant, busy, done, done_id, hundreds, tens, ones
  );

  modport slave (
    input  req, bin_in,
    output grant, busy, done, done_id, hundreds, tens, ones
  );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler around one shift/add-3 binary-to-BCD engine (one bit per clock).
// All outputs come from registers, so there is no combinational path from req.
module bcd_conv_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_conv_scheduler_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [3:0]         wh_q, wh_d, wt_q, wt_d, wo_q, wo_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         id_q, id_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               done_q, done_d;
  logic               busy_q;
  logic [1:0]         done_id_q, done_id_d;
  logic [3:0]         hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [2:0]         cand_c;
  logic [WIDTH-1:0]   op_c;
  logic [3:0]         adj_h, adj_t, adj_o;
  logic [3:0]         step_h, step_t, step_o;

  // The round-robin search starts at ptr_q and wraps modulo NUM_REQ. The first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_c    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_c = {1'b0, ptr_q} + 3'(k);
      if (cand_c >= 3'(NUM_REQ)) cand_c = cand_c - 3'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && bus.req[i] && (cand_c == 3'(i))) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    op_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 2'(i)) op_c = bus.bin_in[i*WIDTH +: WIDTH];
    end
  end

  // One double-dabble step: add 3 to each digit >= 5, then shift {digits, shreg} left by one.
  always_comb begin
    adj_h  = (wh_q >= 4'd5) ? wh_q + 4'd3 : wh_q;
    adj_t  = (wt_q >= 4'd5) ? wt_q + 4'd3 : wt_q;
    adj_o  = (wo_q >= 4'd5) ? wo_q + 4'd3 : wo_q;
    step_h = {adj_h[2:0], adj_t[3]};
    step_t = {adj_t[2:0], adj_o[3]};
    step_o = {adj_o[2:0], shreg_q[WIDTH-1]};
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    wh_d      = wh_q;
    wt_d      = wt_q;
    wo_d      = wo_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          shreg_d = op_c;
          wh_d    = '0;
          wt_d    = '0;
          wo_d    = '0;
          cnt_d   = '0;
          id_d    = win_idx;
          ptr_d   = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (win_idx == 2'(i));
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        wh_d    = step_h;
        wt_d    = step_t;
        wo_d    = step_o;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'(WIDTH - 1)) begin
          hund_d    = step_h;
          tens_d    = step_t;
          ones_d    = step_o;
          done_id_d = id_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      wh_q      <= '0;
      wt_q      <= '0;
      wo_q      <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_id_q <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      wh_q      <= wh_d;
      wt_q      <= wt_d;
      wo_q      <= wo_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= (state_d != S_IDLE);
      done_id_q <= done_id_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.done_id  = done_id_q;
  assign bus.hundreds = hund_q;
  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;
  assign dbg_state_o  = state_q;

endmodule
